// File: rtl/plp_dma_pkg.sv
// Shared types and constants for the PLP data-bus DMA master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package plp_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_WR,
        ST_HOLD,
        ST_FIN
    } state_t;

    localparam logic [1:0] DRW_IDLE  = 2'b00;
    localparam logic [1:0] DRW_WRITE = 2'b01;
    localparam logic [1:0] DRW_READ  = 2'b10;

    // Low address bits cleared on every pointer load (word alignment).
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/plp_dma_ptr.sv
// Loadable word pointer: aligned load, fixed STRIDE post-increment, wraps silently.
// Latency: new value visible the cycle after load/inc.
// Backpressure: none; the caller only pulses inc for accesses that actually happened.
module plp_dma_ptr
    import plp_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // Load wins over increment; the sum wraps modulo 2^ADDR_W.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val & ~ADDR_W'(ALIGN_MASK);
        end else if (inc) begin
            ptr_d = ptr_q + ADDR_W'(STRIDE);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/plp_dma_master.sv
// DMA master: copies len words src->dst over the PLP data bus (fill with src pattern under PLP_DMA_FILL_EN).
// Latency: 1 cycle REQ, then 2 cycles/word (copy) or 1 cycle/word (fill), then a 1-cycle done pulse.
// Backpressure: bus_gnt low on an RD/WR cycle suppresses the access, parks in HOLD and re-requests.
module plp_dma_master
    import plp_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              fill_mode,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  remaining,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              de,
    output logic [ADDR_W-1:0] daddr,
    output logic [1:0]        drw,
    output logic [31:0]       din,
    input  logic [31:0]       dout
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       data_q, data_d;
    logic              phase_wr_q, phase_wr_d;
    logic              fill_q, fill_d;

    logic              fill_start;
    logic              ptr_load, src_inc, dst_inc;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;

    logic              busy_c, done_c, bus_req_c, de_c;
    logic [1:0]        drw_c;
    logic [ADDR_W-1:0] daddr_c;

`ifdef PLP_DMA_FILL_EN
    assign fill_start = fill_mode;
`else
    logic unused_fill;
    assign fill_start  = 1'b0;
    assign unused_fill = fill_mode;
`endif

    plp_dma_ptr #(.ADDR_W(ADDR_W), .STRIDE(STRIDE)) u_src_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (ptr_load),
        .load_val (src),
        .inc      (src_inc),
        .ptr      (src_ptr)
    );

    plp_dma_ptr #(.ADDR_W(ADDR_W), .STRIDE(STRIDE)) u_dst_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (ptr_load),
        .load_val (dst),
        .inc      (dst_inc),
        .ptr      (dst_ptr)
    );

    // Next-state and bus outputs; an access only happens when the grant is present this cycle.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        data_d     = data_q;
        phase_wr_d = phase_wr_q;
        fill_d     = fill_q;
        ptr_load   = 1'b0;
        src_inc    = 1'b0;
        dst_inc    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        bus_req_c  = 1'b0;
        de_c       = 1'b0;
        drw_c      = DRW_IDLE;
        daddr_c    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d    = ST_REQ;
                        ptr_load   = 1'b1;
                        rem_d      = len;
                        fill_d     = fill_start;
                        phase_wr_d = fill_start;
                        if (fill_start) begin
                            data_d = 32'(src);
                        end
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_REQ: begin
                busy_c    = 1'b1;
                bus_req_c = 1'b1;
                if (bus_gnt) begin
                    state_d = phase_wr_q ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                busy_c    = 1'b1;
                bus_req_c = 1'b1;
                if (bus_gnt) begin
                    de_c    = 1'b1;
                    drw_c   = DRW_READ;
                    daddr_c = src_ptr;
                    data_d  = dout;
                    src_inc = 1'b1;
                    state_d = ST_WR;
                end else begin
                    phase_wr_d = 1'b0;
                    state_d    = ST_HOLD;
                end
            end
            ST_WR: begin
                busy_c    = 1'b1;
                bus_req_c = 1'b1;
                if (bus_gnt) begin
                    de_c    = 1'b1;
                    drw_c   = DRW_WRITE;
                    daddr_c = dst_ptr;
                    dst_inc = 1'b1;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = fill_q ? ST_WR : ST_RD;
                    end
                end else begin
                    phase_wr_d = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                busy_c    = 1'b1;
                bus_req_c = 1'b1;
                state_d   = ST_REQ;
            end
            ST_FIN: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and data registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            data_q     <= '0;
            phase_wr_q <= 1'b0;
            fill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            phase_wr_q <= phase_wr_d;
            fill_q     <= fill_d;
        end
    end

    // Gating with rst keeps responders from committing a write at the negedge of a reset cycle.
    assign de        = de_c & ~rst;
    assign drw       = rst ? DRW_IDLE : drw_c;
    assign daddr     = rst ? '0 : daddr_c;
    assign bus_req   = bus_req_c & ~rst;
    assign busy      = busy_c & ~rst;
    assign done      = done_c & ~rst;
    assign din       = data_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_plp_dma_master.sv
// Randomized bench for plp_dma_master against a word-level copy/fill model with a 1 KB responder.
// Latency: done latency checked against REQ + accesses + FIN when the grant is held high.
// Backpressure: grant held high, randomly toggled, or dropped for 3 cycles on the 2nd write.
module tb_plp_dma_master;

    logic        clk = 1'b0;
    logic        rst, start, fill_mode, bus_gnt;
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        busy, done, bus_req, de;
    logic [15:0] remaining;
    logic [31:0] daddr, din, dout;
    logic [1:0]  drw;

    always #5 clk = ~clk;

    plp_dma_master #(.ADDR_W(32), .LEN_W(16), .STRIDE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_mode (fill_mode),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .de        (de),
        .daddr     (daddr),
        .drw       (drw),
        .din       (din),
        .dout      (dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder memory (word index = address bits [9:2]) and bus access log.
    logic [31:0] mem [256];
    logic        init_mem;
    logic [63:0] trace_key [$];
    logic [31:0] trace_dat [$];
    int          viol = 0;
    int          n_wr = 0;
    int          n_rd = 0;

    assign dout = mem[daddr[9:2]];

    always @(negedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= $urandom;
        end
        if (drw == 2'b11) viol++;
        if (de && !bus_gnt) viol++;
        if (de != (drw != 2'b00)) viol++;
        if (de) begin
            trace_key.push_back({30'b0, drw, daddr});
            trace_dat.push_back(drw == 2'b01 ? din : 32'h0);
            if (drw == 2'b01) begin
                mem[daddr[9:2]] <= din;
                n_wr++;
            end else begin
                n_rd++;
            end
        end
    end

    // Grant driver: 0 = held high, 1 = random, 2 = 3-cycle drop on the 2nd write of a transfer.
    int gnt_mode = 0;
    int wr_base  = 0;
    int rd_base  = 0;

    initial begin
        int dropped;
        dropped = 0;
        bus_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                1: bus_gnt = ($urandom_range(0, 3) != 0);
                2: begin
                    if (n_wr - wr_base == 1 && n_rd - rd_base == 2 && dropped < 3) begin
                        bus_gnt = 1'b0;
                        dropped++;
                    end else begin
                        bus_gnt = 1'b1;
                    end
                end
                default: begin
                    bus_gnt = 1'b1;
                    dropped = 0;
                end
            endcase
        end
    end

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int l,
                            input bit f, input int gm, input bit restart);
        logic [31:0] m [256];
        logic [63:0] ek [$];
        logic [31:0] ed [$];
        logic [31:0] sa, da, v;
        int          tb0, v0, lat, exp_lat, nd, nobs;
        bit          got, eff_fill;
`ifdef PLP_DMA_FILL_EN
        eff_fill = f;
`else
        eff_fill = 1'b0;
`endif
        // Reference: word-by-word sequential copy (or pattern fill) on a snapshot of memory.
        for (int i = 0; i < 256; i++) m[i] = mem[i];
        for (int i = 0; i < l; i++) begin
            sa = (s & ~32'h3) + 32'(4 * i);
            da = (d & ~32'h3) + 32'(4 * i);
            if (eff_fill) begin
                ek.push_back({30'b0, 2'b01, da});
                ed.push_back(s);
                m[da[9:2]] = s;
            end else begin
                v = m[sa[9:2]];
                ek.push_back({30'b0, 2'b10, sa});
                ed.push_back(32'h0);
                ek.push_back({30'b0, 2'b01, da});
                ed.push_back(v);
                m[da[9:2]] = v;
            end
        end
        exp_lat = (l == 0) ? 1 : (eff_fill ? l + 2 : 2 * l + 2);

        gnt_mode = gm;
        wr_base  = n_wr;
        rd_base  = n_rd;
        tb0      = trace_key.size();
        v0       = viol;
        @(posedge clk);
        #1;
        start = 1'b1; src = s; dst = d; len = 16'(l); fill_mode = f;
        @(posedge clk);
        #1;
        start = 1'b0; src = $urandom; dst = $urandom; len = 16'($urandom); fill_mode = 1'($urandom);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("busy_after_start", 64'(busy), 64'(l != 0));
                if (l != 0) check("remaining_loaded", 64'(remaining), 64'(l));
            end
            if (restart && n == 3) begin
                start = 1'b1; src = 32'h3F0; dst = 32'h0; len = 16'd9; fill_mode = 1'b0;
            end
            if (restart && n == 4) start = 1'b0;
            if (done) begin
                got = 1'b1;
                lat = n;
                break;
            end
        end
        check("done_seen", 64'(got), 64'(1));
        if (!got) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            return;
        end
        if (gm == 0) check("done_latency", 64'(lat), 64'(exp_lat));
        check("busy_at_done", 64'(busy), 64'(0));
        check("remaining_at_done", 64'(remaining), 64'(0));
        @(negedge clk);
        check("done_pulse_width", 64'(done), 64'(0));
        nobs = trace_key.size() - tb0;
        check("access_count", 64'(nobs), 64'(ek.size()));
        for (int i = 0; i < ek.size() && i < nobs; i++) begin
            check("acc_addr", trace_key[tb0 + i], ek[i]);
            check("acc_data", 64'(trace_dat[tb0 + i]), 64'(ed[i]));
        end
        check("protocol", 64'(viol - v0), 64'(0));
        nd = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== m[i]) nd++;
        check("mem_image", 64'(nd), 64'(0));
    endtask

    // Reset during the 2nd read of a 3-word copy.
    task automatic reset_abort();
        int wr0, seen;
        gnt_mode = 0;
        wr0 = n_wr;
        @(posedge clk);
        #1;
        start = 1'b1; src = 32'h100; dst = 32'h200; len = 16'd3; fill_mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_de_gated", 64'(de), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ctrl", 64'({busy, done, bus_req, de, drw, remaining}), 64'(0));
        check("abort_daddr", 64'(daddr), 64'(0));
        check("abort_din", 64'(din), 64'(0));
        check("abort_writes", 64'(n_wr - wr0), 64'(1));
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy || de) seen++;
        end
        check("no_resume_no_done", 64'(seen), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; fill_mode = 1'b0;
        init_mem = 1'b1;
        @(posedge clk);
        #1 init_mem = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 64'({busy, done, bus_req, de, drw, remaining}), 64'(0));
        check("reset_daddr", 64'(daddr), 64'(0));
        check("reset_din", 64'(din), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        run_xfer(32'h100, 32'h200, 3, 1'b0, 0, 1'b0);
        run_xfer(32'h040, 32'h300, 0, 1'b0, 0, 1'b0);
        run_xfer(32'h100, 32'h200, 4, 1'b0, 2, 1'b0);
        reset_abort();
        run_xfer(32'h080, 32'h280, 4, 1'b0, 0, 1'b1);
        run_xfer(32'hDEADBEEF, 32'h0, 4, 1'b1, 0, 1'b0);
        run_xfer(32'hFFFFFFF8, 32'h7FFFFFFE, 4, 1'b0, 0, 1'b0);
        run_xfer(32'h103, 32'h141, 5, 1'b0, 1, 1'b0);
        for (int t = 0; t < 14; t++) begin
            run_xfer($urandom, $urandom, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
